// File: rtl/palette_port_arbiter.sv
// Purpose: round-robin share of one combinational palette ROM port among NUM_REQ sprite fetchers.
// Latency: 2 cycles from accept (valid&ready) to rsp_valid_o; one lookup per cycle, fully pipelined.
// Backpressure: requesters wait on req_ready_o; the response side has no backpressure.
//
// Ports:
//   clk_i               system clock
//   reset_i             synchronous, active-high reset
//   req_valid_i         per-requester lookup request
//   req_index_i         requester i palette index at [i*IDX_W +: IDX_W]
//   req_ready_o         one-hot grant (combinational from req_valid_i and the rr pointer)
//   pal_index_o         registered index driven to the palette ROM
//   pal_rgb_i           palette ROM output {r,g,b}, combinational from pal_index_o
//   rsp_valid_o         one-hot: response belongs to requester i this cycle
//   rsp_rgb_o           registered RGB for the flagged requester
//   rsp_transparent_o   present only when PAL_TRANSPARENT_EN is defined
//
// Build option: define PAL_TRANSPARENT_EN to add the TRANSP_IDX parameter and the
// rsp_transparent_o flag, which marks responses whose index equals TRANSP_IDX.

module palette_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 8
`ifdef PAL_TRANSPARENT_EN
    ,
    parameter logic [IDX_W-1:0] TRANSP_IDX = '0
`endif
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*IDX_W-1:0] req_index_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [IDX_W-1:0]         pal_index_o,
    input  logic [11:0]              pal_rgb_i,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    output logic [11:0]              rsp_rgb_o
`ifdef PAL_TRANSPARENT_EN
    ,
    output logic                     rsp_transparent_o
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef logic [PTR_W-1:0] ptr_t;

    // Round-robin pointer: the requester searched first in the current cycle.
    ptr_t               ptr_q;
    ptr_t               ptr_d;
    ptr_t               cand;

    logic [NUM_REQ-1:0] grant;
    logic               found;
    logic [IDX_W-1:0]   win_idx;

    // S1: index presented to the ROM plus the tag of who asked for it.
    logic [IDX_W-1:0]   pal_index_q;
    logic [NUM_REQ-1:0] s1_tag_q;
    logic               s1_vld_q;

    // S2: registered ROM result.
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [11:0]        rsp_rgb_q;

    // Arbitration: scan upward from the pointer with wrap, first valid wins.
    // Reset masks every grant so nothing is accepted while the pipeline is being cleared.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        ptr_d = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr_t'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_valid_i[cand]) begin
                grant[cand] = 1'b1;
                found       = 1'b1;
                ptr_d       = ptr_t'((int'(cand) + 1) % NUM_REQ);
            end
        end
        if (reset_i) begin
            grant = '0;
            found = 1'b0;
            ptr_d = ptr_q;
        end
    end

    // Select the winner's index with a one-hot mux; avoids a variable-width part select.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_idx = req_index_i[i*IDX_W +: IDX_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q       <= '0;
            pal_index_q <= '0;
            s1_tag_q    <= '0;
            s1_vld_q    <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rgb_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            s1_vld_q <= found;
            s1_tag_q <= grant;
            // Idle slots leave the ROM address and last colour untouched.
            if (found) begin
                pal_index_q <= win_idx;
            end
            rsp_valid_q <= s1_vld_q ? s1_tag_q : '0;
            if (s1_vld_q) begin
                rsp_rgb_q <= pal_rgb_i;
            end
        end
    end

    assign req_ready_o = grant;
    assign pal_index_o = pal_index_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rgb_o   = rsp_rgb_q;

`ifdef PAL_TRANSPARENT_EN
    // Transparency is decided from the index at S1 and travels alongside the tag.
    logic s1_tr_q;
    logic rsp_tr_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_tr_q  <= 1'b0;
            rsp_tr_q <= 1'b0;
        end else begin
            s1_tr_q  <= found && (win_idx == TRANSP_IDX);
            rsp_tr_q <= s1_tr_q & s1_vld_q;
        end
    end

    assign rsp_transparent_o = rsp_tr_q;
`endif

endmodule

// File: tb/tb_palette_port_arbiter.sv
// Purpose: directed self-checking bench for palette_port_arbiter with NUM_REQ=4 and a stone_palette ROM model.
// Latency: inputs driven 1 time unit after posedge, outputs checked 1 time unit later.
// Backpressure: none modelled on the response side.

module tb_palette_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 8;

    logic                     clk;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*IDX_W-1:0] req_index;
    logic [NUM_REQ-1:0]       req_ready;
    logic [IDX_W-1:0]         pal_index;
    logic [11:0]              pal_rgb;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [11:0]              rsp_rgb;
`ifdef PAL_TRANSPARENT_EN
    logic                     rsp_transparent;
`endif

    int checks;
    int errors;

    palette_port_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .req_valid_i       (req_valid),
        .req_index_i       (req_index),
        .req_ready_o       (req_ready),
        .pal_index_o       (pal_index),
        .pal_rgb_i         (pal_rgb),
        .rsp_valid_o       (rsp_valid),
        .rsp_rgb_o         (rsp_rgb)
`ifdef PAL_TRANSPARENT_EN
        ,
        .rsp_transparent_o (rsp_transparent)
`endif
    );

    // stone_palette ROM model: only the entries the bench exercises.
    always_comb begin
        case (pal_index)
            8'h00:   pal_rgb = 12'h777;
            8'h01:   pal_rgb = 12'h222;
            8'h02:   pal_rgb = 12'h555;
            8'h03:   pal_rgb = 12'h999;
            8'h06:   pal_rgb = 12'h111;
            8'h0A:   pal_rgb = 12'hAAA;
            8'hFF:   pal_rgb = 12'h777;
            default: pal_rgb = 12'h000;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idx(input int i, input logic [7:0] v);
        req_index[i*IDX_W +: IDX_W] = v;
    endtask

    logic [11:0] exp_rgb3 [4];

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        req_valid = 4'hF;
        req_index = {8'h03, 8'h03, 8'h03, 8'h03};

        // 1: reset held 3 cycles with every requester valid.
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_ready", 32'(req_ready), 32'h0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("rst_rsp_rgb", 32'(rsp_rgb), 32'h0);
        end
        chk("rst_pal_index", 32'(pal_index), 32'h0);
`ifdef PAL_TRANSPARENT_EN
        chk("rst_transparent", 32'(rsp_transparent), 32'h0);
`endif

        // 2: req0 alone with index 03.
        reset     = 1'b0;
        req_valid = 4'b0001;
        set_idx(0, 8'h03);
        settle();
        chk("t2_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        settle();
        chk("t2_pal_index", 32'(pal_index), 32'h03);
        chk("t2_rsp_early", 32'(rsp_valid), 32'h0);
        tick();
        chk("t2_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t2_rsp_rgb", 32'(rsp_rgb), 32'h999);

        // Reset again so the round-robin starts from requester 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // 3: all four valid continuously, grants rotate 0,1,2,3,0.
        set_idx(0, 8'h00);
        set_idx(1, 8'h01);
        set_idx(2, 8'h0A);
        set_idx(3, 8'hFF);
        exp_rgb3[0] = 12'h777;
        exp_rgb3[1] = 12'h222;
        exp_rgb3[2] = 12'hAAA;
        exp_rgb3[3] = 12'h777;
        for (int c = 0; c < 7; c++) begin
            req_valid = (c < 5) ? 4'hF : 4'h0;
            settle();
            chk("t3_ready", 32'(req_ready), (c < 5) ? (32'h1 << (c % 4)) : 32'h0);
            if (c >= 2) begin
                chk("t3_rsp_valid", 32'(rsp_valid), 32'h1 << ((c - 2) % 4));
                chk("t3_rsp_rgb", 32'(rsp_rgb), 32'(exp_rgb3[(c - 2) % 4]));
            end else begin
                chk("t3_rsp_idle", 32'(rsp_valid), 32'h0);
            end
            tick();
        end

        // 4: steer the pointer to 3 with a lone req2, then lone req1 wins from pointer 3.
        req_valid = 4'b0100;
        settle();
        chk("t4_ready_r2", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0010;
        set_idx(1, 8'h06);
        settle();
        chk("t4_ready_r1", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'hF;
        settle();
        chk("t4_ptr_is_2", 32'(req_ready), 32'h4);
        chk("t4_rsp_r2_valid", 32'(rsp_valid), 32'h4);
        chk("t4_rsp_r2_rgb", 32'(rsp_rgb), 32'hAAA);
        tick();
        req_valid = 4'h0;
        settle();
        chk("t4_rsp_r1_valid", 32'(rsp_valid), 32'h2);
        chk("t4_rsp_r1_rgb", 32'(rsp_rgb), 32'h111);
        chk("t4_ready_none", 32'(req_ready), 32'h0);
        tick();
        chk("t4_rsp_r2b_valid", 32'(rsp_valid), 32'h4);
        chk("t4_rsp_r2b_rgb", 32'(rsp_rgb), 32'hAAA);
        tick();
        chk("t4_idle_valid", 32'(rsp_valid), 32'h0);
        chk("t4_idle_rgb_hold", 32'(rsp_rgb), 32'hAAA);
        chk("t4_idle_idx_hold", 32'(pal_index), 32'h0A);

        // 5: two accepts (req3 then req0), then reset drops everything in flight.
        req_valid = 4'hF;
        settle();
        chk("t5_ready_r3", 32'(req_ready), 32'h8);
        tick();
        settle();
        chk("t5_ready_r0", 32'(req_ready), 32'h1);
        tick();
        reset = 1'b1;
        settle();
        chk("t5_ready_in_reset", 32'(req_ready), 32'h0);
        tick();
        reset = 1'b0;
        chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("t5_rst_rsp_rgb", 32'(rsp_rgb), 32'h0);
        chk("t5_rst_pal_index", 32'(pal_index), 32'h0);
        settle();
        chk("t5_first_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'h0;
        settle();
        chk("t5_no_stale_rsp", 32'(rsp_valid), 32'h0);
        tick();
        chk("t5_post_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t5_post_rsp_rgb", 32'(rsp_rgb), 32'h777);

`ifdef PAL_TRANSPARENT_EN
        // 6: transparent index 00 versus opaque index 02.
        req_valid = 4'b0001;
        set_idx(0, 8'h00);
        tick();
        set_idx(0, 8'h02);
        tick();
        req_valid = 4'h0;
        settle();
        chk("t6_tr_valid", 32'(rsp_valid), 32'h1);
        chk("t6_tr_rgb", 32'(rsp_rgb), 32'h777);
        chk("t6_tr_flag", 32'(rsp_transparent), 32'h1);
        tick();
        chk("t6_op_valid", 32'(rsp_valid), 32'h1);
        chk("t6_op_rgb", 32'(rsp_rgb), 32'h555);
        chk("t6_op_flag", 32'(rsp_transparent), 32'h0);
        tick();
        chk("t6_idle_flag", 32'(rsp_transparent), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
